// File: rtl/loop_pkg.sv
// Shared types, sizes and helpers for the APU loop sequencer.
package loop_pkg;

  localparam int unsigned BITS                  = 18;
  localparam int unsigned SUPERSCALAR_LOG_WIDTH = 2;
  localparam int unsigned PC_BITS               = 16;
  localparam int unsigned DEPTH                 = 4;
  localparam int unsigned DEPTH_W               = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W                 = $clog2(DEPTH);
  localparam int unsigned STEP_IND              = 1 << SUPERSCALAR_LOG_WIDTH;

  typedef struct packed {
    logic [PC_BITS-1:0] start_pc;
    logic [BITS-1:0]    count;
    logic [BITS-1:0]    iter;
    logic               independent;
  } loop_frame_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ERROR = 2'd2
  } seq_state_t;

  // Iterations retired per pass; one extra bit so iter + step never wraps.
  function automatic logic [BITS:0] loop_step(input logic independent);
    return independent ? (BITS+1)'(STEP_IND) : (BITS+1)'(1);
  endfunction

endpackage

// File: rtl/loop_frame_stack.sv
// Register stack of nested loop frames with push, pop and top-iteration update.
module loop_frame_stack
  import loop_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  loop_frame_t        i_push_frame,
  input  logic               i_pop,
  input  logic               i_upd,
  input  logic [BITS-1:0]    i_upd_iter,
  output loop_frame_t        o_top,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_full,
  output logic               o_empty
);

  loop_frame_t        r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_depth;
  logic [PTR_W-1:0]   w_push_idx;
  logic [PTR_W-1:0]   w_top_idx;

  assign w_push_idx = r_depth[PTR_W-1:0];
  assign w_top_idx  = PTR_W'(r_depth - DEPTH_W'(1));
  assign o_full     = (r_depth == DEPTH_W'(DEPTH));
  assign o_empty    = (r_depth == '0);
  assign o_depth    = r_depth;
  assign o_top      = o_empty ? '0 : r_mem[w_top_idx];

  // Only one stack operation per cycle; the sequencer never asserts two at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !o_full) begin
      r_mem[w_push_idx] <= i_push_frame;
      r_depth           <= r_depth + DEPTH_W'(1);
    end else if (i_pop && !o_empty) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end else if (i_upd && !o_empty) begin
      r_mem[w_top_idx].iter <= i_upd_iter;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Decodes start_loop/end_loop, manages the loop frame stack and issues loop-back jumps.
module loop_sequencer
  import loop_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic               instr_is_loop_start,
  input  logic               instr_is_loop_end,
  input  logic [PC_BITS-1:0] instr_pc,
  input  logic [BITS-1:0]    loop_count,
  input  logic               loop_independent,
  output logic               jump_valid,
  output logic [PC_BITS-1:0] jump_target,
  output logic               loop_done,
  output logic [BITS-1:0]    current_iteration,
  output logic [DEPTH_W-1:0] depth,
  output logic               error
);

  seq_state_t         r_state;
  logic               r_jump_valid;
  logic [PC_BITS-1:0] r_jump_target;
  logic               r_loop_done;
  logic               r_error;

  loop_frame_t        w_top;
  loop_frame_t        w_push_frame;
  logic               w_full;
  logic               w_empty;
  logic               w_run;
  logic               w_both;
  logic               w_start;
  logic               w_end;
  logic               w_push;
  logic               w_end_ok;
  logic               w_fault;
  logic [BITS:0]      w_next;
  logic               w_more;
  logic               w_upd;
  logic               w_pop;

  // Instruction decode; only RUN accepts instructions.
  assign w_run    = (r_state == ST_RUN) && instr_valid;
  assign w_both   = w_run && instr_is_loop_start && instr_is_loop_end;
  assign w_start  = w_run && instr_is_loop_start && !instr_is_loop_end;
  assign w_end    = w_run && instr_is_loop_end && !instr_is_loop_start;
  assign w_push   = w_start && !w_full;
  assign w_end_ok = w_end && !w_empty;
  assign w_fault  = w_both || (w_start && w_full) || (w_end && w_empty);

  // Do-while compare in BITS+1 bits so count 0 and 1 both exit after one pass.
  assign w_next = {1'b0, w_top.iter} + loop_step(w_top.independent);
  assign w_more = (w_next < {1'b0, w_top.count});
  assign w_upd  = w_end_ok && w_more;
  assign w_pop  = w_end_ok && !w_more;

  assign w_push_frame = '{start_pc:    instr_pc + PC_BITS'(1),
                          count:       loop_count,
                          iter:        '0,
                          independent: loop_independent};

  loop_frame_stack u_stack (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_frame (w_push_frame),
    .i_pop        (w_pop),
    .i_upd        (w_upd),
    .i_upd_iter   (BITS'(w_next)),
    .o_top        (w_top),
    .o_depth      (depth),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_jump_valid  <= 1'b0;
      r_jump_target <= '0;
      r_loop_done   <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_jump_valid <= 1'b0;
      r_loop_done  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_fault) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else if (w_upd) begin
            r_jump_valid  <= 1'b1;
            r_jump_target <= w_top.start_pc;
            r_state       <= ST_FLUSH;
          end else if (w_pop) begin
            r_loop_done <= 1'b1;
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        ST_ERROR: r_state <= ST_ERROR;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign jump_valid        = r_jump_valid;
  assign jump_target       = r_jump_target;
  assign loop_done         = r_loop_done;
  assign error             = r_error;
  assign current_iteration = w_top.iter;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer.
module tb_loop_sequencer;
  import loop_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               instr_valid;
  logic               instr_is_loop_start;
  logic               instr_is_loop_end;
  logic [PC_BITS-1:0] instr_pc;
  logic [BITS-1:0]    loop_count;
  logic               loop_independent;
  logic               jump_valid;
  logic [PC_BITS-1:0] jump_target;
  logic               loop_done;
  logic [BITS-1:0]    current_iteration;
  logic [DEPTH_W-1:0] depth;
  logic               error;

  int vectors = 0;
  int miscompares = 0;

  loop_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_valid         (instr_valid),
    .instr_is_loop_start (instr_is_loop_start),
    .instr_is_loop_end   (instr_is_loop_end),
    .instr_pc            (instr_pc),
    .loop_count          (loop_count),
    .loop_independent    (loop_independent),
    .jump_valid          (jump_valid),
    .jump_target         (jump_target),
    .loop_done           (loop_done),
    .current_iteration   (current_iteration),
    .depth               (depth),
    .error               (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one instruction for one posedge, returns at the next negedge.
  task automatic instr(input logic s, input logic e, input int pc, input int cnt, input logic ind);
    instr_valid         = 1'b1;
    instr_is_loop_start = s;
    instr_is_loop_end   = e;
    instr_pc            = PC_BITS'(pc);
    loop_count          = BITS'(cnt);
    loop_independent    = ind;
    @(negedge clk);
    instr_valid         = 1'b0;
    instr_is_loop_start = 1'b0;
    instr_is_loop_end   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Checks the outcome of an end_loop: jump to tgt with new iter, or exit.
  task automatic chk_end(input string tag, input logic jmp, input int tgt, input int it, input int dep);
    chk({tag, ".jv"}, 32'(jump_valid), 32'(jmp));
    chk({tag, ".done"}, 32'(loop_done), 32'(!jmp));
    if (jmp) chk({tag, ".tgt"}, 32'(jump_target), 32'(tgt));
    chk({tag, ".iter"}, 32'(current_iteration), 32'(it));
    chk({tag, ".depth"}, 32'(depth), 32'(dep));
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    instr_is_loop_start = 1'b0;
    instr_is_loop_end = 1'b0;
    instr_pc = '0;
    loop_count = '0;
    loop_independent = 1'b0;
    #1;
    chk("rst.jv", 32'(jump_valid), 0);
    chk("rst.tgt", 32'(jump_target), 0);
    chk("rst.done", 32'(loop_done), 0);
    chk("rst.iter", 32'(current_iteration), 0);
    chk("rst.depth", 32'(depth), 0);
    chk("rst.err", 32'(error), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single dependent loop, count 3 at pc 10
    instr(1, 0, 10, 3, 0);
    chk("s.push.depth", 32'(depth), 1);
    chk("s.push.jv", 32'(jump_valid), 0);
    chk("s.push.iter", 32'(current_iteration), 0);
    idle(2);
    instr(0, 1, 0, 0, 0); chk_end("s.e1", 1, 11, 1, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("s.e2", 1, 11, 2, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("s.e3", 0, 0, 0, 0); idle(2);

    // Independent loop, count 12: passes at iter 0,4,8
    instr(1, 0, 50, 12, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i12.e1", 1, 51, 4, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i12.e2", 1, 51, 8, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i12.e3", 0, 0, 0, 0); idle(2);

    // Independent loop, count 13: passes at iter 0,4,8,12
    instr(1, 0, 60, 13, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i13.e1", 1, 61, 4, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i13.e2", 1, 61, 8, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i13.e3", 1, 61, 12, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("i13.e4", 0, 0, 0, 0); idle(2);

    // Nesting: outer count 2 at pc 0, inner count 2 at pc 1
    instr(1, 0, 0, 2, 0); chk("n.o.depth", 32'(depth), 1); idle(1);
    instr(1, 0, 1, 2, 0); chk("n.i.depth", 32'(depth), 2); idle(1);
    instr(0, 1, 0, 0, 0); chk_end("n.e1", 1, 2, 1, 2); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("n.e2", 0, 0, 0, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("n.e3", 1, 1, 1, 1); idle(2);
    instr(1, 0, 1, 2, 0); chk("n.i2.depth", 32'(depth), 2); idle(1);
    instr(0, 1, 0, 0, 0); chk_end("n.e4", 1, 2, 1, 2); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("n.e5", 0, 0, 1, 1); idle(2);
    instr(0, 1, 0, 0, 0); chk_end("n.e6", 0, 0, 0, 0); idle(2);

    // start_loop presented during FLUSH is dropped
    instr(1, 0, 20, 2, 0); idle(1);
    instr(0, 1, 0, 0, 0); chk_end("f.e1", 1, 21, 1, 1);
    instr(1, 0, 30, 5, 0);
    chk("f.depth", 32'(depth), 1);
    chk("f.jv", 32'(jump_valid), 0);
    chk("f.err", 32'(error), 0);
    instr(0, 1, 0, 0, 0); chk_end("f.e2", 0, 0, 0, 0); idle(1);

    // Overflow: fifth push faults and leaves the stack at 4
    for (int i = 0; i < 4; i++) instr(1, 0, 100 + i, 3, 0);
    chk("ov.depth4", 32'(depth), 4);
    chk("ov.err0", 32'(error), 0);
    instr(1, 0, 200, 3, 0);
    chk("ov.err", 32'(error), 1);
    chk("ov.depth", 32'(depth), 4);
    instr(0, 1, 0, 0, 0);
    chk("ov.nojump", 32'(jump_valid), 0);
    chk("ov.nopop", 32'(loop_done), 0);
    chk("ov.depth2", 32'(depth), 4);
    idle(3);
    chk("ov.sticky", 32'(error), 1);
    do_reset();
    chk("ov.rst.err", 32'(error), 0);
    chk("ov.rst.depth", 32'(depth), 0);

    // Underflow: end_loop on empty stack
    instr(0, 1, 0, 0, 0);
    chk("un.err", 32'(error), 1);
    chk("un.jv", 32'(jump_valid), 0);
    chk("un.done", 32'(loop_done), 0);
    instr(1, 0, 5, 3, 0);
    chk("un.nopush", 32'(depth), 0);
    idle(3);
    chk("un.sticky", 32'(error), 1);
    do_reset();
    chk("un.rst.err", 32'(error), 0);

    // Both start and end flags together
    instr(1, 1, 7, 3, 0);
    chk("both.err", 32'(error), 1);
    chk("both.depth", 32'(depth), 0);
    do_reset();

    // Reset mid-loop drops an in-flight jump
    instr(1, 0, 40, 3, 0); idle(1);
    instr_valid = 1'b1;
    instr_is_loop_end = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_is_loop_end = 1'b0;
    chk("rm.jv.pre", 32'(jump_valid), 1);
    reset = 1'b0;
    #1;
    chk("rm.jv", 32'(jump_valid), 0);
    chk("rm.depth", 32'(depth), 0);
    chk("rm.iter", 32'(current_iteration), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    instr(1, 0, 70, 1, 0); idle(1);
    instr(0, 1, 0, 0, 0); chk_end("rm.e1", 0, 0, 0, 0);
    chk("rm.err", 32'(error), 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Control-unit block that issues loop-back jumps for the APU instruction stream.
- Decodes start_loop/end_loop instructions and keeps a hardware stack of nested loop frames.
- On each end_loop it either issues a jump to the loop body start or pops the frame and falls through.
- It is the initiator side of the loop-iteration interface: it produces the jump/increment events that per-loop iteration counters consume.

Parameters:
- BITS, 18, width of iteration count and iteration index
- SUPERSCALAR_LOG_WIDTH, 2, log2 of iterations retired per pass in an independent loop
- PC_BITS, 16, program counter width
- DEPTH, 4, maximum loop nesting depth (power of 2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset; asserted when 0
- instr_valid  input  1  decoded instruction present this cycle
- instr_is_loop_start  input  1  instruction is start_loop
- instr_is_loop_end  input  1  instruction is end_loop
- instr_pc  input  PC_BITS  PC of the current instruction
- loop_count  input  BITS  iteration count operand of start_loop
- loop_independent  input  1  start_loop operand: loop is inner independent (vectorised)
- jump_valid  output  1  one-cycle pulse: redirect fetch
- jump_target  output  PC_BITS  target PC; valid while jump_valid is high
- loop_done  output  1  one-cycle pulse: innermost loop exited
- current_iteration  output  BITS  iteration index of the top frame; 0 when the stack is empty
- depth  output  $clog2(DEPTH)+1  number of live frames
- error  output  1  sticky fault flag

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, stack empty, state RUN.
- Frame contents: start_pc, count, iter, independent.
- Step size: 2^SUPERSCALAR_LOG_WIDTH if the frame is independent, else 1.
- Loop semantics are do-while: the body always executes at least once, so count 0 and count 1 behave identically.
- start_loop, accepted in RUN with depth<DEPTH:
  - push frame {start_pc=instr_pc+1, count=loop_count, iter=0, independent=loop_independent}
  - depth increments on the next edge
  - no jump is issued
- end_loop, accepted in RUN with depth>0:
  - compute next = iter + step in BITS+1 bits (no wrap)
  - if next < count: on the next edge, jump_valid=1, jump_target=top.start_pc, top.iter=next, and the state goes to FLUSH
  - else: pop the frame, pulse loop_done=1 on the next edge, no jump
- Pass counts:
  - independent loop with count=12 and step 4: 3 passes (iter 0,4,8)
  - count=13: 4 passes (iter 0,4,8,12)
- Latency: jump_valid/loop_done are registered and appear exactly 1 cycle after the end_loop cycle.
- State machine:
  - RUN: instructions are accepted.
  - FLUSH: lasts exactly one cycle, concurrent with jump_valid high. instr_valid is ignored (wrong-path instruction), then the state returns to RUN.
  - ERROR: sticky; error=1; no further jumps, pushes or pops; exited only by reset.
- Transitions into ERROR (the stack is left unchanged in every case):
  - start_loop with depth==DEPTH (overflow)
  - end_loop with depth==0 (underflow)
  - instr_is_loop_start and instr_is_loop_end both high with instr_valid
- Instructions with neither flag set have no effect.
- current_iteration and depth reflect registered stack state; they update on the same edge as the push, pop or increment.
- After a pop, current_iteration shows the outer frame's iter.
- Asserting reset mid-loop clears the stack immediately. A jump_valid already in flight is dropped.

Decomposition:
- Package loop_pkg:
  - loop_frame_t struct (start_pc, count, iter, independent)
  - sequencer state enum {RUN, FLUSH, ERROR}
  - function loop_step(independent) returning the step size
- Sub-module loop_frame_stack:
  - DEPTH-entry register stack with push, pop and top-update ports
  - exposes top frame, depth, full and empty
  - the sequencer FSM and compare logic live in loop_sequencer.

Test Plan:
- Single loop:
  - Stimulus: start_loop pc=10 count=3 independent=0, then end_loop three times, two idle cycles between each.
  - Required response: jump_valid with jump_target=11 after the 1st and 2nd end_loop, current_iteration 1 then 2; after the 3rd end_loop, loop_done=1, depth=0, no jump.
- Independent loop:
  - Stimulus: start_loop count=12 independent=1, then end_loop repeated.
  - Required response: exactly 2 jumps, current_iteration 4 then 8; loop_done on the 3rd end_loop.
  - Repeat with count=13: required response is 3 jumps.
- Nesting:
  - Stimulus: outer count=2 at pc=0, inner count=2 at pc=1, end_loop sequence.
  - Required response: depth goes 1,2,1,2,1,0; jump targets 2,1,2 in order; total inner passes = 4.
- FLUSH:
  - Stimulus: present start_loop in the cycle where jump_valid=1.
  - Required response: the instruction is ignored and depth is unchanged.
- Errors:
  - Stimulus: push 5 frames with DEPTH=4.
  - Required response: error=1 and depth stays 4.
  - Stimulus: after reset, end_loop with an empty stack.
  - Required response: error=1.
  - In both cases, error stays high until reset=0.
- Reset mid-loop:
  - Stimulus: pull reset low on the cycle after an end_loop that should jump.
  - Required response: jump_valid=0 immediately and depth=0; after release, a new start_loop count=1 followed by end_loop gives loop_done with no jump.
